ras_spec: RTL and testbench

Speculative, parametrised return address stack for the superscalar fetch stage. It processes up to WIDTH fetched instructions per cycle, predicts the target of the first return in the bundle, and stores return addresses as a circular stack. Checkpoints taken at predicted branches allow the stack to be restored when the backend signals a mispredict. It sits beside the branch predictor in fetch and is driven by predecode.

---
 rtl/ras_pkg.sv | 38 +++
 rtl/ras_if.sv | 43 ++++
 rtl/ras_bundle_scan.sv | 51 +++++
 rtl/ras_spec.sv | 146 ++++++++++++++
 tb/tb_ras_spec.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ras_pkg.sv
// ras_pkg: shared configuration, types and helpers for the return address stack.
// The stack geometry (XLEN, WIDTH, DEPTH, NCKPT) lives here so the interface,
// the bundle scanner and the top level all agree on widths.
package ras_pkg;

    localparam int XLEN  = 32;  // address width
    localparam int WIDTH = 2;   // fetch slots per cycle, >= 1
    localparam int DEPTH = 16;  // stack entries, power of two, >= 2
    localparam int NCKPT = 8;   // checkpoint slots, power of two

    localparam int RAS_PTR_W   = $clog2(DEPTH);
    localparam int RAS_CNT_W   = RAS_PTR_W + 1;
    localparam int RAS_TAG_W   = $clog2(NCKPT);
    localparam int RAS_SLOT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RAS_NCALL_W = $clog2(WIDTH + 1);
    // Wide enough to hold count + pushes before saturation.
    localparam int RAS_SUM_W   = $clog2(DEPTH + WIDTH + 1);

    typedef logic [RAS_PTR_W-1:0]   ras_ptr_t;
    typedef logic [RAS_CNT_W-1:0]   ras_cnt_t;
    typedef logic [RAS_TAG_W-1:0]   ras_tag_t;
    typedef logic [RAS_SLOT_W-1:0]  ras_slot_t;
    typedef logic [RAS_NCALL_W-1:0] ras_ncall_t;
    typedef logic [RAS_SUM_W-1:0]   ras_sum_t;
    typedef logic [XLEN-1:0]        ras_addr_t;

    typedef struct packed {
        ras_ptr_t  ptr;
        ras_cnt_t  count;
        ras_addr_t top;
    } ras_ckpt_t;

    // Return address pushed by a call at pc.
    function automatic ras_addr_t ret_addr(input ras_addr_t pc);
        return pc + ras_addr_t'(4);
    endfunction

endpackage

// File: rtl/ras_if.sv
// ras_if: fetch-side bundle into the return address stack and the prediction
// coming back out, plus debug visibility of the stack pointer and count.
//
// Handshake: there is no ready. fetch_valid[i] qualifies slot i for the cycle
// it is presented; predict_valid qualifies predict_slot/pc/hit in that same
// cycle (combinational). ckpt_req and recover are single-cycle strobes.
//
// Modports: master = predecode/backend side, slave = ras_spec.
interface ras_if;
    import ras_pkg::*;

    logic [WIDTH-1:0]            fetch_valid;
    logic [WIDTH-1:0][XLEN-1:0]  fetch_pc;
    logic [WIDTH-1:0]            is_call;
    logic [WIDTH-1:0]            is_return;
    logic                        ckpt_req;
    ras_tag_t                    ckpt_tag;
    logic                        recover;
    ras_tag_t                    recover_tag;

    logic                        predict_valid;
    ras_slot_t                   predict_slot;
    ras_addr_t                   predict_pc;
    logic                        predict_hit;

    ras_ptr_t                    dbg_ptr;
    ras_cnt_t                    dbg_count;

    modport master (
        output fetch_valid, fetch_pc, is_call, is_return,
               ckpt_req, ckpt_tag, recover, recover_tag,
        input  predict_valid, predict_slot, predict_pc, predict_hit,
               dbg_ptr, dbg_count
    );

    modport slave (
        input  fetch_valid, fetch_pc, is_call, is_return,
               ckpt_req, ckpt_tag, recover, recover_tag,
        output predict_valid, predict_slot, predict_pc, predict_hit,
               dbg_ptr, dbg_count
    );

endinterface

// File: rtl/ras_bundle_scan.sv
// ras_bundle_scan: combinational scan of one fetch bundle.
// Inputs : fetch_valid, is_call, is_return (one bit per slot, slot 0 oldest).
// Outputs: ret_found/ret_slot  - first valid return (a call+return counts as return)
//          num_calls/last_call - calls before that return (whole bundle if none)
//          push_en/push_off    - which slots write the stack and at ptr+offset
module ras_bundle_scan
    import ras_pkg::*;
(
    input  logic [WIDTH-1:0]       fetch_valid,
    input  logic [WIDTH-1:0]       is_call,
    input  logic [WIDTH-1:0]       is_return,
    output logic                   ret_found,
    output ras_slot_t              ret_slot,
    output ras_ncall_t             num_calls,
    output ras_slot_t              last_call,
    output logic [WIDTH-1:0]       push_en,
    output ras_ptr_t [WIDTH-1:0]   push_off
);

    logic blocked;

    always_comb begin
        ret_found = 1'b0;
        ret_slot  = '0;
        num_calls = '0;
        last_call = '0;
        push_en   = '0;
        push_off  = '0;
        blocked   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!blocked && fetch_valid[i]) begin
                if (is_return[i]) begin
                    ret_found = 1'b1;
                    ret_slot  = ras_slot_t'(i);
                    blocked   = 1'b1;
                end else if (is_call[i]) begin
                    push_en[i]  = 1'b1;
                    push_off[i] = ras_ptr_t'(num_calls);
                    num_calls   = num_calls + ras_ncall_t'(1);
                    last_call   = ras_slot_t'(i);
                end
            end
        end
        // The return consumes the last call's address directly; it never lands
        // in the stack.
        if (ret_found && (num_calls != '0)) begin
            push_en[last_call] = 1'b0;
        end
    end

endmodule

// File: rtl/ras_spec.sv
// ras_spec: speculative circular return address stack for superscalar fetch.
// Ports: clock, reset (synchronous, active-high), bus (ras_if.slave) carrying
// the fetch bundle, checkpoint/recover controls and the return prediction.
// Prediction is combinational from the current state and the bundle; the
// stack, pointer, count and checkpoint slots update on the rising edge.
module ras_spec
    import ras_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    ras_if.slave  bus
);

    logic                  ret_found;
    ras_slot_t             ret_slot;
    ras_ncall_t            num_calls;
    ras_slot_t             last_call;
    logic [WIDTH-1:0]      push_en;
    ras_ptr_t [WIDTH-1:0]  push_off;

    ras_bundle_scan u_scan (
        .fetch_valid (bus.fetch_valid),
        .is_call     (bus.is_call),
        .is_return   (bus.is_return),
        .ret_found   (ret_found),
        .ret_slot    (ret_slot),
        .num_calls   (num_calls),
        .last_call   (last_call),
        .push_en     (push_en),
        .push_off    (push_off)
    );

    ras_ptr_t   ptr_q, ptr_d;
    ras_cnt_t   count_q, count_d;
    ras_addr_t  stack_q [DEPTH];
    ras_addr_t  stack_d [DEPTH];
    ras_ckpt_t  ckpt_q  [NCKPT];
    ras_ckpt_t  ckpt_d  [NCKPT];

    ras_ptr_t   top_idx;
    ras_ptr_t   wr_idx;
    ras_ptr_t   new_top_idx;
    ras_ptr_t   rec_idx;
    ras_ckpt_t  rec;
    ras_ncall_t net_push;
    ras_sum_t   cnt_sum;

    logic       pred_valid;
    ras_slot_t  pred_slot;
    ras_addr_t  pred_pc;
    logic       pred_hit;

    assign top_idx = ptr_q - ras_ptr_t'(1);

    // Prediction: youngest in-bundle call wins, then the stack top, then
    // fall back to the return's own pc+4 (reported as a miss).
    always_comb begin
        pred_valid = 1'b0;
        pred_slot  = '0;
        pred_pc    = '0;
        pred_hit   = 1'b0;
        if (!reset && ret_found) begin
            pred_valid = 1'b1;
            pred_slot  = ret_slot;
            if (num_calls != '0) begin
                pred_pc  = ret_addr(bus.fetch_pc[last_call]);
                pred_hit = 1'b1;
            end else if (count_q != '0) begin
                pred_pc  = stack_q[top_idx];
                pred_hit = 1'b1;
            end else begin
                pred_pc  = ret_addr(bus.fetch_pc[ret_slot]);
            end
        end
    end

    assign bus.predict_valid = pred_valid;
    assign bus.predict_slot  = pred_slot;
    assign bus.predict_pc    = pred_pc;
    assign bus.predict_hit   = pred_hit;
    assign bus.dbg_ptr       = ptr_q;
    assign bus.dbg_count     = count_q;

    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        stack_d     = stack_q;
        ckpt_d      = ckpt_q;
        wr_idx      = '0;
        new_top_idx = '0;
        net_push    = '0;
        cnt_sum     = '0;
        rec         = ckpt_q[bus.recover_tag];
        rec_idx     = rec.ptr - ras_ptr_t'(1);

        if (bus.recover) begin
            // Only the top entry is restored; deeper entries keep whatever
            // speculative contents they have.
            ptr_d            = rec.ptr;
            count_d          = rec.count;
            stack_d[rec_idx] = rec.top;
        end else begin
            if (ret_found && (num_calls == '0)) begin
                // Pop from the stack; an empty stack stays put.
                if (count_q != '0) begin
                    ptr_d   = top_idx;
                    count_d = count_q - ras_cnt_t'(1);
                end
            end else begin
                // With a return, the last call is consumed rather than stored.
                net_push = ret_found ? (num_calls - ras_ncall_t'(1)) : num_calls;
                for (int i = 0; i < WIDTH; i++) begin
                    if (push_en[i]) begin
                        wr_idx          = ptr_q + push_off[i];
                        stack_d[wr_idx] = ret_addr(bus.fetch_pc[i]);
                    end
                end
                ptr_d   = ptr_q + ras_ptr_t'(net_push);
                cnt_sum = ras_sum_t'(count_q) + ras_sum_t'(net_push);
                count_d = (cnt_sum > ras_sum_t'(DEPTH)) ? ras_cnt_t'(DEPTH)
                                                        : ras_cnt_t'(cnt_sum);
            end
            // Snapshot the post-bundle state, including this cycle's writes.
            if (bus.ckpt_req) begin
                new_top_idx           = ptr_d - ras_ptr_t'(1);
                ckpt_d[bus.ckpt_tag]  = '{ptr: ptr_d, count: count_d,
                                          top: stack_d[new_top_idx]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            for (int i = 0; i < NCKPT; i++) ckpt_q[i]  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            stack_q <= stack_d;
            ckpt_q  <= ckpt_d;
        end
    end

endmodule

// File: tb/tb_ras_spec.sv
// tb_ras_spec: directed and randomized bench for ras_spec with a behavioural
// model of the return stack checked every cycle on the falling edge.
module tb_ras_spec;
    import ras_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   run_chk = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] exp_q[$];

    ras_if bus ();

    ras_spec dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // ---------------- model state ----------------
    int              m_ptr;
    int              m_cnt;
    logic [XLEN-1:0] m_stack [DEPTH];
    int              ck_ptr  [NCKPT];
    int              ck_cnt  [NCKPT];
    logic [XLEN-1:0] ck_top  [NCKPT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_stack[i] = '0;
        for (int i = 0; i < NCKPT; i++) begin
            ck_ptr[i] = 0;
            ck_cnt[i] = 0;
            ck_top[i] = '0;
        end
    endtask

    // One cycle of the stack, stated as: collect the return addresses of the
    // calls ahead of the first return, predict, then apply the net effect.
    task automatic model_cycle();
        logic [XLEN-1:0] calls[$];
        int              r;
        bit              had_calls;
        logic [XLEN-1:0] e_pc;
        bit              e_hit;
        int              t;
        r = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (r < 0 && bus.fetch_valid[i]) begin
                if (bus.is_return[i]) r = i;
                else if (bus.is_call[i]) calls.push_back(bus.fetch_pc[i] + 32'd4);
            end
        end
        had_calls = (calls.size() > 0);
        e_pc  = '0;
        e_hit = 1'b0;
        if (r >= 0) begin
            if (had_calls) begin
                e_pc = calls[calls.size()-1];
                e_hit = 1'b1;
            end else if (m_cnt > 0) begin
                e_pc = m_stack[(m_ptr + DEPTH - 1) % DEPTH];
                e_hit = 1'b1;
            end else begin
                e_pc = bus.fetch_pc[r] + 32'd4;
            end
        end
        chk("predict_valid", 64'(bus.predict_valid), 64'(r >= 0));
        chk("predict_slot",  64'(bus.predict_slot),  64'((r >= 0) ? r : 0));
        chk("predict_pc",    64'(bus.predict_pc),    64'(e_pc));
        chk("predict_hit",   64'(bus.predict_hit),   64'(e_hit));
        chk("ptr",           64'(bus.dbg_ptr),       64'(m_ptr));
        chk("count",         64'(bus.dbg_count),     64'(m_cnt));

        if (bus.recover) begin
            t = int'(bus.recover_tag);
            m_ptr = ck_ptr[t];
            m_cnt = ck_cnt[t];
            m_stack[(m_ptr + DEPTH - 1) % DEPTH] = ck_top[t];
        end else begin
            if (r >= 0 && !had_calls) begin
                if (m_cnt > 0) begin
                    m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                    m_cnt = m_cnt - 1;
                end
            end else begin
                if (r >= 0) calls.pop_back();
                for (int k = 0; k < calls.size(); k++)
                    m_stack[(m_ptr + k) % DEPTH] = calls[k];
                m_ptr = (m_ptr + calls.size()) % DEPTH;
                m_cnt = (m_cnt + calls.size() > DEPTH) ? DEPTH : m_cnt + calls.size();
            end
            if (bus.ckpt_req) begin
                t = int'(bus.ckpt_tag);
                ck_ptr[t] = m_ptr;
                ck_cnt[t] = m_cnt;
                ck_top[t] = m_stack[(m_ptr + DEPTH - 1) % DEPTH];
            end
        end
    endtask

    // Single compare process: every falling edge.
    always @(negedge clock) begin
        if (run_chk) begin
            if (reset) begin
                chk("rst_predict_valid", 64'(bus.predict_valid), 64'd0);
                chk("rst_predict_slot",  64'(bus.predict_slot),  64'd0);
                chk("rst_predict_pc",    64'(bus.predict_pc),    64'd0);
                chk("rst_predict_hit",   64'(bus.predict_hit),   64'd0);
                model_reset();
            end else begin
                model_cycle();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.fetch_valid = '0;
        bus.fetch_pc    = '0;
        bus.is_call     = '0;
        bus.is_return   = '0;
        bus.ckpt_req    = 1'b0;
        bus.ckpt_tag    = '0;
        bus.recover     = 1'b0;
        bus.recover_tag = '0;
    endtask

    task automatic set_slot(input int s, input bit c, input bit r, input logic [XLEN-1:0] pc);
        bus.fetch_valid[s] = 1'b1;
        bus.is_call[s]     = c;
        bus.is_return[s]   = r;
        bus.fetch_pc[s]    = pc;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_cycle(input int call_bias);
        int kind;
        for (int s = 0; s < WIDTH; s++) begin
            if ($urandom_range(0, 3) != 0) begin
                kind = $urandom_range(0, 9);
                set_slot(s, (kind < call_bias) || (kind == 9), (kind >= call_bias && kind < 9) || (kind == 9),
                         {$urandom_range(0, 32'h3fff_ffff), 2'b00});
                if (kind == 8) bus.is_return[s] = 1'b0;
            end
        end
        bus.ckpt_req    = ($urandom_range(0, 3) == 0);
        bus.ckpt_tag    = ras_tag_t'($urandom_range(0, NCKPT - 1));
        bus.recover     = ($urandom_range(0, 9) == 0);
        bus.recover_tag = ras_tag_t'($urandom_range(0, NCKPT - 1));
        reset           = ($urandom_range(0, 299) == 0);
        tick();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        model_reset();
        run_chk = 1'b1;
        // Outputs stay zero under reset even with a return presented.
        set_slot(0, 1'b0, 1'b1, 32'h300);
        tick();
        do_reset();

        // Call then return next cycle.
        set_slot(0, 1'b1, 1'b0, 32'h100);
        tick();
        set_slot(0, 1'b0, 1'b1, 32'h500);
        #1;
        chk("lit_pop_pc",  64'(bus.predict_pc),  64'h104);
        chk("lit_pop_hit", 64'(bus.predict_hit), 64'd1);
        tick();
        chk("lit_pop_count", 64'(bus.dbg_count), 64'd0);

        // Call and return in one bundle.
        set_slot(0, 1'b1, 1'b0, 32'h200);
        set_slot(1, 1'b0, 1'b1, 32'h204);
        #1;
        chk("lit_same_valid", 64'(bus.predict_valid), 64'd1);
        chk("lit_same_slot",  64'(bus.predict_slot),  64'd1);
        chk("lit_same_pc",    64'(bus.predict_pc),    64'h204);
        tick();
        chk("lit_same_ptr",   64'(bus.dbg_ptr),   64'd0);
        chk("lit_same_count", 64'(bus.dbg_count), 64'd0);

        // Return on an empty stack.
        set_slot(0, 1'b0, 1'b1, 32'h300);
        #1;
        chk("lit_empty_hit", 64'(bus.predict_hit), 64'd0);
        chk("lit_empty_pc",  64'(bus.predict_pc),  64'h304);
        tick();
        chk("lit_empty_ptr", 64'(bus.dbg_ptr), 64'd0);

        // Overflow: DEPTH+2 calls, then DEPTH returns.
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_slot(0, 1'b1, 1'b0, 32'h1000 + 32'(4 * i));
            tick();
        end
        chk("lit_ovf_count", 64'(bus.dbg_count), 64'(DEPTH));
        for (int i = DEPTH + 1; i >= 2; i--) exp_q.push_back(32'h1000 + 32'(4 * i) + 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            set_slot(0, 1'b0, 1'b1, 32'h9000);
            #1;
            chk("lit_ovf_pop", 64'(bus.predict_pc), 64'(exp_q.pop_front()));
            tick();
        end

        // Checkpoint after two calls, speculate, recover.
        do_reset();
        set_slot(0, 1'b1, 1'b0, 32'h10);
        set_slot(1, 1'b1, 1'b0, 32'h20);
        bus.ckpt_req = 1'b1;
        bus.ckpt_tag = ras_tag_t'(3);
        tick();
        set_slot(0, 1'b0, 1'b1, 32'h600);
        tick();
        set_slot(0, 1'b0, 1'b1, 32'h604);
        tick();
        set_slot(0, 1'b1, 1'b0, 32'h40);
        tick();
        bus.recover = 1'b1;
        bus.recover_tag = ras_tag_t'(3);
        tick();
        set_slot(0, 1'b0, 1'b1, 32'h700);
        #1;
        chk("lit_recover_pc", 64'(bus.predict_pc), 64'h24);
        tick();

        // Recover alongside a call and a same-tag checkpoint write.
        set_slot(0, 1'b1, 1'b0, 32'h80);
        bus.recover = 1'b1;
        bus.recover_tag = ras_tag_t'(3);
        bus.ckpt_req = 1'b1;
        bus.ckpt_tag = ras_tag_t'(3);
        tick();
        chk("lit_rec_call_ptr",   64'(bus.dbg_ptr),   64'd2);
        chk("lit_rec_call_count", 64'(bus.dbg_count), 64'd2);
        set_slot(0, 1'b0, 1'b1, 32'h704);
        tick();
        bus.recover = 1'b1;
        bus.recover_tag = ras_tag_t'(3);
        tick();
        chk("lit_rec_drop_ptr", 64'(bus.dbg_ptr), 64'd2);

        // Random traffic, alternating call-heavy and return-heavy phases.
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 400; c++) rand_cycle((ph % 2 == 0) ? 6 : 3);
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
